// File: rtl/immgen_stage.sv
// -----------------------------------------------------------------------------
// immgen_stage
//
// Registered immediate generator for an RV32I (optionally RV64) datapath.
// Each accepted instruction word is decoded into its immediate format and an
// XLEN-wide extended immediate. The result travels with a sideband tag through
// a 2-entry elastic buffer: an output register plus one skid register. This
// lets the input ready be a flop while still sustaining one instruction per
// cycle.
//
// Parameters
//   XLEN   32 or 64. Width of out_imm. With 64, OP-IMM-32 also decodes as I.
//   TAG_W  Width of the sideband tag (typically the PC).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (has priority over flush)
//   flush        drop every held entry at the next edge; same-cycle input lost
//   in_valid     instruction present on in_instr
//   in_ready     stage can accept this cycle (registered)
//   in_instr     raw 32-bit instruction word
//   in_tag       sideband value, returned unchanged with the result
//   out_valid    decoded result valid
//   out_ready    consumer accepts this cycle
//   out_imm      extended immediate
//   out_fmt      R=0 I=1 S=2 B=3 U=4 J=5 Z=6 X=7
//   out_illegal  opcode not recognised (fmt X)
//   out_tag      tag of the entry on the output
//
// Build option
//   IMMGEN_STAGE_CSR_ZIMM_EN  when defined, SYSTEM with funct3[2]=1 yields
//                             fmt Z and imm = zero-extended instr[19:15].
//                             When undefined, every SYSTEM opcode is fmt I.
// -----------------------------------------------------------------------------
module immgen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   // --------------------------------------------------------------------------
   // Types and opcode constants
   // --------------------------------------------------------------------------
   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5,
      FMT_Z = 3'd6,
      FMT_X = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,  // nothing held
      ONE   = 2'd1,  // output register full
      TWO   = 2'd2   // output and skid registers full
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      fmt_e             fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;

   // --------------------------------------------------------------------------
   // Combinational decode of the incoming word
   // --------------------------------------------------------------------------
   logic [6:0]        opcode;
   fmt_e              dec_fmt;
   logic signed [31:0] imm32;
   entry_t            dec_entry;

   assign opcode = in_instr[6:0];

   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path
      // through the block leaves one unassigned and no latch is inferred.
      dec_fmt = FMT_X;
      imm32   = '0;

      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: dec_fmt = FMT_I;
         OP_STORE:                            dec_fmt = FMT_S;
         OP_BRANCH:                           dec_fmt = FMT_B;
         OP_LUI, OP_AUIPC:                    dec_fmt = FMT_U;
         OP_JAL:                              dec_fmt = FMT_J;
         OP_REG:                              dec_fmt = FMT_R;
         OP_IMM_32:                           dec_fmt = (XLEN == 64) ? FMT_I : FMT_X;
         default:                             dec_fmt = FMT_X;
      endcase

`ifdef IMMGEN_STAGE_CSR_ZIMM_EN
      // CSR immediate forms (CSRRWI/CSRRSI/CSRRCI) carry a 5-bit zimm in rs1.
      if (opcode == OP_SYSTEM && in_instr[14]) begin
         dec_fmt = FMT_Z;
      end
`endif

      // Immediates are assembled as 32-bit signed values; the final widening
      // to XLEN is a single sign extension shared by every format. The Z
      // immediate is non-negative at 32 bits, so that extension zero-fills it.
      case (dec_fmt)
         FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: imm32 = {in_instr[31:12], 12'b0};
         FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
         FMT_Z: imm32 = {27'b0, in_instr[19:15]};
         default: imm32 = '0;  // R and X carry a zero immediate
      endcase

      dec_entry.imm     = XLEN'(imm32);
      dec_entry.fmt     = dec_fmt;
      dec_entry.illegal = (dec_fmt == FMT_X);
      dec_entry.tag     = in_tag;
   end

   // --------------------------------------------------------------------------
   // Elastic buffer control
   // --------------------------------------------------------------------------
   state_e state;
   state_e state_nxt;
   entry_t out_q;
   entry_t skid_q;
   logic   accept;
   logic   drain;
   logic   load_out;
   logic   load_skid;
   logic   skid_to_out;

   // in_ready is a flop that always equals (state != TWO), so accept is
   // already suppressed while both registers are full.
   assign accept    = in_valid & in_ready;
   assign out_valid = (state != EMPTY);
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_nxt   = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;

      if (flush) begin
         // Drop everything, including any word offered this cycle.
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = ONE;
                  load_out  = 1'b1;
               end
            end
            ONE: begin
               case ({accept, drain})
                  2'b10: begin            // consumer stalled: park in skid
                     state_nxt = TWO;
                     load_skid = 1'b1;
                  end
                  2'b01: state_nxt = EMPTY;
                  2'b11: load_out = 1'b1; // pass-through at full rate
                  default: ;
               endcase
            end
            TWO: begin
               if (drain) begin
                  state_nxt   = ONE;
                  skid_to_out = 1'b1;     // older skid entry moves forward
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         out_q    <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != TWO);
         if (load_out) begin
            out_q <= dec_entry;
         end else if (skid_to_out) begin
            out_q <= skid_q;
         end
      end
   end

   // NOTE: the skid register is pure datapath with no reset; it is only ever
   // read in state TWO, which can only be reached by first writing it.
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_q <= dec_entry;
      end
   end

   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign out_tag     = out_q.tag;

   // --------------------------------------------------------------------------
   // Protocol properties
   // --------------------------------------------------------------------------
   // A stalled output must hold every signal until it is taken or flushed.
   a_stall_stable : assert property (
      @(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_q))
   );

   // The ready flop mirrors the occupancy state.
   a_ready_matches_state : assert property (
      @(posedge clk) disable iff (rst)
      (in_ready == (state != TWO))
   );

endmodule

// File: tb/tb_immgen_stage.sv
// -----------------------------------------------------------------------------
// tb_immgen_stage
//
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus. A queue
// holds the instruction words the stage currently owns; the expected outputs
// are computed from the front entry with plain integer arithmetic per format.
// Directed checks with literal values pin the model at the points of interest.
// -----------------------------------------------------------------------------
module tb_immgen_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        in_ready32, out_valid32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [31:0] tag32;

   logic        in_ready64, out_valid64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [31:0] tag64;

   immgen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
   );

   immgen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
   );

   // --------------------------------------------------------------------------
   // Model
   // --------------------------------------------------------------------------
   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] tag;
   } item_t;

   item_t q[$];          // words owned by the stage, oldest first
   logic  m_ready;       // expected in_ready for the current cycle
   bit    chk_en = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   function automatic exp_t model(input logic [31:0] w, input int xlen);
      exp_t       e;
      longint     s;
      longint     imm;
      logic [6:0] op;
      s     = longint'($signed(w));
      op    = w[6:0];
      imm   = 0;
      e.fmt = 3'd7;
      if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 ||
          (xlen == 64 && op == 7'h1B)) begin
         e.fmt = 3'd1;
         imm   = s >>> 20;
      end else if (op == 7'h23) begin
         e.fmt = 3'd2;
         imm   = (s >>> 25) * 32 + longint'(w[11:7]);
      end else if (op == 7'h63) begin
         e.fmt = 3'd3;
         imm   = (s >>> 31) * 4096 + longint'(w[7]) * 2048 +
                 longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      end else if (op == 7'h37 || op == 7'h17) begin
         e.fmt = 3'd4;
         imm   = (s >>> 12) * 4096;
      end else if (op == 7'h6F) begin
         e.fmt = 3'd5;
         imm   = (s >>> 31) * 1048576 + longint'(w[19:12]) * 4096 +
                 longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      end else if (op == 7'h33) begin
         e.fmt = 3'd0;
      end
`ifdef IMMGEN_STAGE_CSR_ZIMM_EN
      if (op == 7'h73 && w[14]) begin
         e.fmt = 3'd6;
         imm   = longint'(w[19:15]);
      end
`endif
      e.ill = (e.fmt == 3'd7);
      e.imm = (xlen == 32) ? (64'(imm) & 64'hFFFF_FFFF) : 64'(imm);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Per-cycle compare against the model (outputs settle after posedge)
   // --------------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e32;
      exp_t e64;
      if (chk_en) begin
         check("valid32", 64'(out_valid32), 64'(q.size() != 0));
         check("valid64", 64'(out_valid64), 64'(q.size() != 0));
         check("ready32", 64'(in_ready32),  64'(m_ready));
         check("ready64", 64'(in_ready64),  64'(m_ready));
         if (q.size() != 0) begin
            e32 = model(q[0].instr, 32);
            e64 = model(q[0].instr, 64);
            check("imm32", 64'(imm32), e32.imm);
            check("fmt32", 64'(fmt32), 64'(e32.fmt));
            check("ill32", 64'(ill32), 64'(e32.ill));
            check("tag32", 64'(tag32), 64'(q[0].tag));
            check("imm64", imm64,      e64.imm);
            check("fmt64", 64'(fmt64), 64'(e64.fmt));
            check("ill64", 64'(ill64), 64'(e64.ill));
            check("tag64", 64'(tag64), 64'(q[0].tag));
         end
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus helpers
   // --------------------------------------------------------------------------
   // Apply one cycle of inputs, then advance the model across the edge.
   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] t,
                        input logic ordy, input logic fl, input logic r);
      logic acc;
      logic drn;
      @(negedge clk);
      in_valid  = v;
      in_instr  = w;
      in_tag    = t;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      @(posedge clk);
      acc = v && m_ready;
      drn = (q.size() != 0) && ordy;
      if (r || fl) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back('{instr: w, tag: t});
      end
      m_ready = (q.size() < 2);
   endtask

   // Literal expectations for the entry on the output just after an edge.
   // The XLEN=32 immediate is the low half of the XLEN=64 one.
   task automatic pin(input string name, input logic [63:0] want_imm,
                      input logic [2:0] want_fmt, input logic want_ill,
                      input logic [31:0] want_tag);
      #1;
      check({name, " valid"}, 64'(out_valid32), 64'd1);
      check({name, " imm32"}, 64'(imm32), 64'(want_imm[31:0]));
      check({name, " imm64"}, imm64, want_imm);
      check({name, " fmt"},   64'(fmt32), 64'(want_fmt));
      check({name, " ill"},   64'(ill32), 64'(want_ill));
      check({name, " tag"},   64'(tag64), 64'(want_tag));
   endtask

   task automatic pin_idle(input string name);
      #1;
      check({name, " valid32"}, 64'(out_valid32), 64'd0);
      check({name, " valid64"}, 64'(out_valid64), 64'd0);
      check({name, " ready32"}, 64'(in_ready32), 64'd1);
      check({name, " ready64"}, 64'(in_ready64), 64'd1);
   endtask

   task automatic pin_reset(input string name);
      pin_idle(name);
      check({name, " imm32"}, 64'(imm32), 64'd0);
      check({name, " imm64"}, imm64, 64'd0);
      check({name, " fmt"},   64'(fmt32), 64'd0);
      check({name, " ill"},   64'(ill32), 64'd0);
      check({name, " tag"},   64'(tag32), 64'd0);
   endtask

   // Mixed words covering every opcode class, with varied bit patterns.
   localparam int NTBL = 14;
   logic [31:0] tbl [NTBL] = '{
      32'h8A1F_0513, 32'h7E55_2E23, 32'h9C3A_8AE3, 32'h5A5A_51B7,
      32'hC0FF_E097, 32'hA5C3_D0EF, 32'h40B5_0533, 32'h3412_9073,
      32'h0000_5F73, 32'h8765_4067, 32'hF0F0_4003, 32'h0010_009B,
      32'h1234_567F, 32'h0000_000F
   };

   localparam logic [31:0] W_S = 32'h0011_2623;

   // --------------------------------------------------------------------------
   // Directed sequence
   // --------------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      m_ready   = 1'b1;

      drive(0, 0, 0, 0, 0, 1);
      chk_en = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      pin_reset("reset");

      // Back-to-back formats, one cycle latency, full throughput.
      drive(1, 32'hFFF0_0093, 32'h10, 1, 0, 0);
      pin("fmt_i", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 0, 32'h10);
      drive(1, W_S, 32'h11, 1, 0, 0);
      pin("fmt_s", 64'h0000_0000_0000_000C, 3'd2, 0, 32'h11);
      drive(1, 32'hFE00_0EE3, 32'h12, 1, 0, 0);
      pin("fmt_b", 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 0, 32'h12);
      drive(1, 32'h1234_50B7, 32'h13, 1, 0, 0);
      pin("fmt_u", 64'h0000_0000_1234_5000, 3'd4, 0, 32'h13);
      drive(1, 32'h0010_00EF, 32'h14, 1, 0, 0);
      pin("fmt_j", 64'h0000_0000_0000_0800, 3'd5, 0, 32'h14);
      drive(1, 32'h0000_007F, 32'h15, 1, 0, 0);
      pin("fmt_x", 64'h0, 3'd7, 1, 32'h15);
      drive(1, 32'h3002_D073, 32'h16, 1, 0, 0);
`ifdef IMMGEN_STAGE_CSR_ZIMM_EN
      pin("csr", 64'h5, 3'd6, 0, 32'h16);
`else
      pin("csr", 64'h300, 3'd1, 0, 32'h16);
`endif
      drive(1, 32'h8000_00B7, 32'h17, 1, 0, 0);
      pin("u_sext", 64'hFFFF_FFFF_8000_0000, 3'd4, 0, 32'h17);
      drive(0, 0, 0, 1, 0, 0);
      pin_idle("drained");

      // Backpressure: tags 1,2 fill the buffer, 3 waits, then in-order release.
      drive(1, W_S, 32'd1, 0, 0, 0);
      pin("bp_first", 64'hC, 3'd2, 0, 32'd1);
      drive(1, W_S, 32'd2, 0, 0, 0);
      #1;
      check("bp ready_low32", 64'(in_ready32), 64'd0);
      check("bp ready_low64", 64'(in_ready64), 64'd0);
      drive(1, W_S, 32'd3, 0, 0, 0);
      pin("bp_hold", 64'hC, 3'd2, 0, 32'd1);
      drive(1, W_S, 32'd3, 1, 0, 0);
      pin("bp_out2", 64'hC, 3'd2, 0, 32'd2);
      drive(1, W_S, 32'd3, 1, 0, 0);
      pin("bp_out3", 64'hC, 3'd2, 0, 32'd3);
      drive(0, 0, 0, 1, 0, 0);
      pin_idle("bp_done");

      // Flush while full, with a word offered in the flush cycle.
      drive(1, W_S, 32'h21, 0, 0, 0);
      drive(1, W_S, 32'h22, 0, 0, 0);
      drive(1, W_S, 32'h23, 0, 1, 0);
      pin_idle("flush_two");
      drive(0, 0, 0, 1, 0, 0);
      pin_idle("flush_two_after");

      // Flush in ONE while an accept and a drain would otherwise happen.
      drive(1, W_S, 32'h30, 0, 0, 0);
      drive(1, W_S, 32'h31, 1, 1, 0);
      pin_idle("flush_one");
      drive(0, 0, 0, 1, 0, 0);
      pin_idle("flush_one_after");

      // Reset with two entries held; reset wins over a simultaneous flush.
      drive(1, W_S, 32'h40, 0, 0, 0);
      drive(1, 32'hFFF0_0093, 32'h41, 0, 0, 0);
      drive(1, W_S, 32'h42, 1, 1, 1);
      pin_reset("reset_mid");
      drive(0, 0, 0, 1, 0, 0);

      // Mixed traffic with irregular valid/ready and one flush.
      for (int i = 0; i < 60; i++) begin
         drive((i % 5) != 4, tbl[i % NTBL], 32'h100 + i, (i % 3) != 2, i == 37, 0);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 0, 0);
      end
      pin_idle("final");

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/immgen_stage.md
# immgen_stage

Registered, parametrised immediate generator for the RV32I datapath with a valid/ready handshake and a 2-entry skid buffer. It decodes every base-ISA immediate format (I, S, B, U, J) into an XLEN-wide sign-extended value, classifies the format, and carries a sideband tag (typically the PC) alongside. It sits between the fetch/instruction register and the decode/execute stage, so the pipelined core can stall and flush without losing or duplicating instructions.

## Interface
- XLEN, 32: output width; legal values are 32 and 64. With 64, OP-IMM-32 (0011011) also decodes as I.
- TAG_W, 32: width of the sideband tag carried with each instruction.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discards all held entries at the next edge.
- in_valid  in  1  instruction present on `in_instr`.
- in_ready  out  1  stage can accept this cycle; registered output.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband value, returned unchanged.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  sign- or zero-extended immediate.
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, X(illegal)=7.
- out_illegal  out  1  set when the opcode is unrecognised (fmt X).
- out_tag  out  TAG_W  tag of the entry on the output.

## Operation
- Decode is combinational from `in_instr`; the result is captured with the tag into the output register or the skid register.
- Opcode to format:
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, with imm 0.
  - Any other opcode: X, with imm 0 and `out_illegal`=1.
- Immediate assembly. Every I/S/B/J immediate sign-extends from instr[31] to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Entry states: EMPTY, ONE (output register full), TWO (output and skid full).
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept with no drain → TWO.
  - ONE + drain with no accept → EMPTY.
  - ONE + accept and drain → ONE.
  - TWO + drain → ONE, with the skid entry moving to the output register.
- Terms: accept = `in_valid` & `in_ready`; drain = `out_valid` & `out_ready`.
- `in_ready` = state != TWO, registered. Accept is ignored in TWO.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Flush: next state is EMPTY regardless of accept or drain in the same cycle. An input offered in the flush cycle is discarded. `in_ready` is 1 the cycle after.
- Payload outputs (`out_imm`, `out_fmt`, `out_illegal`, `out_tag`) hold their last value when `out_valid`=0; consumers must ignore them.

## Timing
- Latency: 1 cycle from accept to `out_valid` when EMPTY.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Reset values:
  - `out_valid`=0, `in_ready`=1.
  - `out_imm`=0, `out_fmt`=0, `out_illegal`=0, `out_tag`=0.
  - State EMPTY.
- Reset mid-operation: all entries are lost and the reset values apply on the next edge. Reset takes priority over flush.
- While `out_valid`=1 and `out_ready`=0, all output signals are stable.
- After `out_ready` deasserts, at most one further instruction is accepted before `in_ready` falls.

## Configuration
- Macro: `IMMGEN_STAGE_CSR_ZIMM_EN`.
- Defined: SYSTEM (1110011) with funct3[2]=1 gives fmt Z and imm = zero-extended instr[19:15]. SYSTEM with funct3[2]=0 stays fmt I.
- Undefined: all SYSTEM opcodes give fmt I with the I-type immediate. Code 6 is never produced.

## Test plan
- I and S formats, XLEN=32: 0xFFF00093 → imm 0xFFFFFFFF, fmt 1. 0x00112623 → imm 0x0000000C, fmt 2. Each result appears 1 cycle after accept.
- B, U and J formats: 0xFE000EE3 → imm 0xFFFFFFFC, fmt 3. 0x123450B7 → imm 0x12345000, fmt 4. 0x001000EF → imm 0x00000800, fmt 5. 0x0000007F → fmt 7, illegal 1, imm 0.
- Backpressure:
  - Stimulus: hold `out_ready`=0, stream tags 1, 2, 3.
  - Required: `in_ready` falls after the 2nd accept and tag 3 waits.
  - Release `out_ready`: tags appear in order 1, 2, 3 with no gaps or duplicates.
- Flush in state TWO with `in_valid`=1 in the same cycle: next cycle `out_valid`=0 and `in_ready`=1. The flushed-cycle input never appears on the output.
- `IMMGEN_STAGE_CSR_ZIMM_EN` with 0x3002D073:
  - Macro defined: imm 0x5, fmt 6.
  - Macro undefined: imm 0x300, fmt 1.
- XLEN=64: 0x800000B7 → imm 0xFFFFFFFF80000000. Asserting `rst` with 2 entries held → `out_valid`=0 and `in_ready`=1 next cycle.
